// File: rtl/conv_transpose3d_tap_sequencer.sv
// rtl/conv_transpose3d_tap_sequencer.sv - gather-form tap/commit sequencer for 3D grouped transposed convolution
module conv_transpose3d_tap_sequencer #(
  parameter int CIN    = 4,
  parameter int COUT   = 4,
  parameter int GROUPS = 2,
  parameter int K      = 3,
  parameter int STRIDE = 2,
  parameter int PAD    = 1,
  parameter int ID     = 2,
  parameter int IH     = 3,
  parameter int IW     = 4,
  parameter int AW     = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          tap_valid,
  input  logic          tap_ready,
  output logic [AW-1:0] tap_in_addr,
  output logic [AW-1:0] tap_w_addr,
  output logic          tap_first,
  output logic          commit_valid,
  input  logic          commit_ready,
  output logic [AW-1:0] commit_addr,
  output logic          commit_empty
);

  localparam int OD  = (ID - 1) * STRIDE - 2 * PAD + K;
  localparam int OH  = (IH - 1) * STRIDE - 2 * PAD + K;
  localparam int OW  = (IW - 1) * STRIDE - 2 * PAD + K;
  localparam int CPG = CIN / GROUPS;
  localparam int OPG = COUT / GROUPS;
  localparam int SH  = $clog2(STRIDE);

  localparam logic [AW-1:0] K_LAST   = AW'(K - 1);
  localparam logic [AW-1:0] OD_LAST  = AW'(OD - 1);
  localparam logic [AW-1:0] OH_LAST  = AW'(OH - 1);
  localparam logic [AW-1:0] OW_LAST  = AW'(OW - 1);
  localparam logic [AW-1:0] CPG_LAST = AW'(CPG - 1);
  localparam logic [AW-1:0] OPG_LAST = AW'(OPG - 1);
  localparam logic [AW-1:0] G_LAST   = AW'(GROUPS - 1);
  localparam logic [AW-1:0] PAD_A    = AW'(PAD);
  localparam logic [AW-1:0] S_MASK   = AW'(STRIDE - 1);
  localparam logic [AW-1:0] ID_A     = AW'(ID);
  localparam logic [AW-1:0] IH_A     = AW'(IH);
  localparam logic [AW-1:0] IW_A     = AW'(IW);
  localparam logic [AW-1:0] K_A      = AW'(K);
  localparam logic [AW-1:0] KK_A     = AW'(K * K);
  localparam logic [AW-1:0] CPG_A    = AW'(CPG);
  localparam logic [AW-1:0] OPG_A    = AW'(OPG);
  localparam logic [AW-1:0] IN_STEP  = AW'(ID * IH * IW);
  localparam logic [AW-1:0] W_STEP   = AW'(OPG * K * K * K);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_EMIT, S_COMMIT, S_DONE} state_t;

  state_t state_q, state_d;

  // Loop counters; output channel is kept as (group, channel-in-group) to avoid a divider.
  logic [AW-1:0] g_q, ocm_q, od_q, oh_q, ow_q;
  logic [AW-1:0] kd_q, kh_q, kw_q, ci_q;
  logic [AW-1:0] in_addr_q, w_addr_q, commit_addr_q;
  logic          any_q;

  logic          scan_ok, k_last, ci_last, vox_last, tap_hs, commit_hs;
  logic [AW-1:0] i_d, i_h, i_w;
  logic [AW-1:0] kd_n, kh_n, kw_n;
  logic [AW-1:0] in_base, w_base;

  // A tap lands on a real input sample when o+PAD-k is non-negative, stride-aligned and in range.
  function automatic logic axis_ok(input logic [AW-1:0] o, input logic [AW-1:0] k,
                                   input logic [AW-1:0] imax);
    logic [AW-1:0] t;
    t = o + PAD_A - k;
    return (o + PAD_A >= k) && ((t & S_MASK) == '0) && ((t >> SH) < imax);
  endfunction

  // Tap validity, loop-end flags and the next kernel index.
  always_comb begin
    scan_ok   = axis_ok(od_q, kd_q, ID_A) && axis_ok(oh_q, kh_q, IH_A) && axis_ok(ow_q, kw_q, IW_A);
    i_d       = (od_q + PAD_A - kd_q) >> SH;
    i_h       = (oh_q + PAD_A - kh_q) >> SH;
    i_w       = (ow_q + PAD_A - kw_q) >> SH;
    k_last    = (kd_q == K_LAST) && (kh_q == K_LAST) && (kw_q == K_LAST);
    ci_last   = (ci_q == CPG_LAST);
    vox_last  = (g_q == G_LAST) && (ocm_q == OPG_LAST) && (od_q == OD_LAST) &&
                (oh_q == OH_LAST) && (ow_q == OW_LAST);
    tap_hs    = (state_q == S_EMIT) && tap_ready;
    commit_hs = (state_q == S_COMMIT) && commit_ready;
    kw_n      = (kw_q == K_LAST) ? '0 : kw_q + 1'b1;
    kh_n      = (kw_q == K_LAST) ? ((kh_q == K_LAST) ? '0 : kh_q + 1'b1) : kh_q;
    kd_n      = (kw_q == K_LAST && kh_q == K_LAST) ? ((kd_q == K_LAST) ? '0 : kd_q + 1'b1) : kd_q;
    in_base   = ((g_q * CPG_A * ID_A + i_d) * IH_A + i_h) * IW_A + i_w;
    w_base    = ((g_q * CPG_A * OPG_A + ocm_q) * K_A + kd_q) * KK_A + kh_q * K_A + kw_q;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_SCAN;
      S_SCAN:   if (scan_ok) state_d = S_EMIT;
                else if (k_last) state_d = S_COMMIT;
      S_EMIT:   if (tap_hs && ci_last) state_d = k_last ? S_COMMIT : S_SCAN;
      S_COMMIT: if (commit_hs) state_d = vox_last ? S_DONE : S_SCAN;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counters and address registers; the commit address simply counts voxels since ow is innermost.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_q <= '0; ocm_q <= '0; od_q <= '0; oh_q <= '0; ow_q <= '0;
      kd_q <= '0; kh_q <= '0; kw_q <= '0; ci_q <= '0;
      in_addr_q <= '0; w_addr_q <= '0; commit_addr_q <= '0; any_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          g_q <= '0; ocm_q <= '0; od_q <= '0; oh_q <= '0; ow_q <= '0;
          kd_q <= '0; kh_q <= '0; kw_q <= '0; ci_q <= '0;
          commit_addr_q <= '0; any_q <= 1'b0;
        end
        S_SCAN: if (scan_ok) begin
          ci_q      <= '0;
          in_addr_q <= in_base;
          w_addr_q  <= w_base;
        end else begin
          kd_q <= kd_n; kh_q <= kh_n; kw_q <= kw_n;
        end
        S_EMIT: if (tap_hs) begin
          any_q <= 1'b1;
          if (ci_last) begin
            kd_q <= kd_n; kh_q <= kh_n; kw_q <= kw_n;
          end else begin
            ci_q      <= ci_q + 1'b1;
            in_addr_q <= in_addr_q + IN_STEP;
            w_addr_q  <= w_addr_q + W_STEP;
          end
        end
        S_COMMIT: if (commit_hs) begin
          any_q         <= 1'b0;
          commit_addr_q <= commit_addr_q + 1'b1;
          kd_q <= '0; kh_q <= '0; kw_q <= '0;
          if (ow_q != OW_LAST) ow_q <= ow_q + 1'b1;
          else begin
            ow_q <= '0;
            if (oh_q != OH_LAST) oh_q <= oh_q + 1'b1;
            else begin
              oh_q <= '0;
              if (od_q != OD_LAST) od_q <= od_q + 1'b1;
              else begin
                od_q <= '0;
                if (ocm_q != OPG_LAST) ocm_q <= ocm_q + 1'b1;
                else begin
                  ocm_q <= '0;
                  g_q   <= g_q + 1'b1;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from the registered state and address registers only.
  always_comb begin
    busy         = (state_q == S_SCAN) || (state_q == S_EMIT) || (state_q == S_COMMIT);
    done         = (state_q == S_DONE);
    tap_valid    = (state_q == S_EMIT);
    commit_valid = (state_q == S_COMMIT);
    tap_first    = (state_q == S_EMIT) && !any_q;
    commit_empty = (state_q == S_COMMIT) && !any_q;
    tap_in_addr  = in_addr_q;
    tap_w_addr   = w_addr_q;
    commit_addr  = commit_addr_q;
  end

endmodule

// File: tb/tb_conv_transpose3d_tap_sequencer.sv
// tb/tb_conv_transpose3d_tap_sequencer.sv - randomized self-checking bench with a loop-nest reference model
module tb_conv_transpose3d_tap_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Three instances: small O=3 config, K=1 sparse config, defaults.
  logic a_start = 0, a_rdy = 0, a_busy, a_done, a_tv, a_first, a_cv, a_empty;
  logic b_start = 0, b_rdy = 0, b_busy, b_done, b_tv, b_first, b_cv, b_empty;
  logic c_start = 0, c_rdy = 0, c_busy, c_done, c_tv, c_first, c_cv, c_empty;
  logic [15:0] a_in, a_w, a_ca, b_in, b_w, b_ca, c_in, c_w, c_ca;

  conv_transpose3d_tap_sequencer #(.CIN(1), .COUT(1), .GROUPS(1), .K(3), .STRIDE(2), .PAD(1),
    .ID(2), .IH(2), .IW(2), .AW(16)) u_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
    .tap_valid(a_tv), .tap_ready(a_rdy), .tap_in_addr(a_in), .tap_w_addr(a_w), .tap_first(a_first),
    .commit_valid(a_cv), .commit_ready(a_rdy), .commit_addr(a_ca), .commit_empty(a_empty));

  conv_transpose3d_tap_sequencer #(.CIN(1), .COUT(1), .GROUPS(1), .K(1), .STRIDE(2), .PAD(0),
    .ID(2), .IH(2), .IW(2), .AW(16)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
    .tap_valid(b_tv), .tap_ready(b_rdy), .tap_in_addr(b_in), .tap_w_addr(b_w), .tap_first(b_first),
    .commit_valid(b_cv), .commit_ready(b_rdy), .commit_addr(b_ca), .commit_empty(b_empty));

  conv_transpose3d_tap_sequencer u_c (
    .clk(clk), .rst(rst), .start(c_start), .busy(c_busy), .done(c_done),
    .tap_valid(c_tv), .tap_ready(c_rdy), .tap_in_addr(c_in), .tap_w_addr(c_w), .tap_first(c_first),
    .commit_valid(c_cv), .commit_ready(c_rdy), .commit_addr(c_ca), .commit_empty(c_empty));

  typedef struct {
    bit is_commit;
    int in_a;
    int w_a;
    bit first;
    int c_a;
    bit empty;
  } beat_t;

  beat_t exp_q[$];

  int tap_cnt, commit_cnt, done_cnt, last_commit_cyc, grp_cnt;
  int first_in, first_w, first_first, first_ca, last_in, last_w, last_ca;
  bit rand_en = 0;

  bit          prev_stall[3];
  logic [15:0] sv_in[3], sv_w[3], sv_ca[3];
  logic        sv_first[3], sv_tv[3], sv_cv[3], sv_empty[3];

  function automatic void chk(string name, int act, int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endfunction

  // Reference: walk the output voxels in gather form straight from the index equations.
  task automatic build_model(input int cin, input int cout, input int groups, input int k,
                             input int s, input int p, input int idd, input int ih, input int iw);
    int odn, ohn, own, cpg, opg, td, th, tw, ci_abs;
    bit any, ok;
    beat_t b;
    odn = (idd - 1) * s - 2 * p + k;
    ohn = (ih - 1) * s - 2 * p + k;
    own = (iw - 1) * s - 2 * p + k;
    cpg = cin / groups;
    opg = cout / groups;
    exp_q.delete();
    for (int oc = 0; oc < cout; oc++)
      for (int od = 0; od < odn; od++)
        for (int oh = 0; oh < ohn; oh++)
          for (int ow = 0; ow < own; ow++) begin
            any = 0;
            for (int kd = 0; kd < k; kd++)
              for (int kh = 0; kh < k; kh++)
                for (int kw = 0; kw < k; kw++) begin
                  td = od + p - kd; th = oh + p - kh; tw = ow + p - kw;
                  ok = (td >= 0) && (th >= 0) && (tw >= 0) &&
                       (td % s == 0) && (th % s == 0) && (tw % s == 0) &&
                       (td / s < idd) && (th / s < ih) && (tw / s < iw);
                  if (ok)
                    for (int ci = 0; ci < cpg; ci++) begin
                      ci_abs      = (oc / opg) * cpg + ci;
                      b.is_commit = 0;
                      b.in_a      = ((ci_abs * idd + td / s) * ih + th / s) * iw + tw / s;
                      b.w_a       = ((ci_abs * opg + oc % opg) * k + kd) * k * k + kh * k + kw;
                      b.first     = !any;
                      b.c_a       = ((oc * odn + od) * ohn + oh) * own + ow;
                      b.empty     = 0;
                      exp_q.push_back(b);
                      any = 1;
                    end
                end
            b.is_commit = 1;
            b.in_a      = 0;
            b.w_a       = 0;
            b.first     = 0;
            b.c_a       = ((oc * odn + od) * ohn + oh) * own + ow;
            b.empty     = !any;
            exp_q.push_back(b);
          end
  endtask

  function automatic void check_beat(bit is_c, int in_a, int w_a, bit first, int c_a, bit empty);
    beat_t e;
    chk("beat_expected", int'(exp_q.size() > 0), 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("beat_kind", is_c, e.is_commit);
      chk("commit_addr", c_a, e.c_a);
      if (is_c) begin
        chk("commit_empty", empty, e.empty);
      end else begin
        chk("tap_in_addr", in_a, e.in_a);
        chk("tap_w_addr", w_a, e.w_a);
        chk("tap_first", first, e.first);
      end
    end
  endfunction

  function automatic void monitor(int id, logic tv, logic cv, logic rdy, logic busy, logic done,
                                  logic [15:0] in_a, logic [15:0] w_a, logic [15:0] c_a,
                                  logic first, logic empty);
    if (rst) begin
      prev_stall[id] = 0;
      return;
    end
    if (tv || cv) chk("valid_exclusive", int'(tv && cv), 0);
    if (prev_stall[id]) begin
      chk("stall_tap_valid", tv, sv_tv[id]);
      chk("stall_commit_valid", cv, sv_cv[id]);
      chk("stall_in_addr", in_a, sv_in[id]);
      chk("stall_w_addr", w_a, sv_w[id]);
      chk("stall_commit_addr", c_a, sv_ca[id]);
      chk("stall_first", first, sv_first[id]);
      chk("stall_empty", empty, sv_empty[id]);
    end
    prev_stall[id] = (tv || cv) && !rdy;
    sv_tv[id] = tv; sv_cv[id] = cv; sv_in[id] = in_a; sv_w[id] = w_a;
    sv_ca[id] = c_a; sv_first[id] = first; sv_empty[id] = empty;
    if (tv && rdy) begin
      check_beat(0, in_a, w_a, first, c_a, 0);
      if (id == 0) begin
        if (tap_cnt == 0) begin
          first_in = in_a; first_w = w_a; first_first = first; first_ca = c_a;
        end
        last_in = in_a; last_w = w_a; last_ca = c_a;
      end
      if (id == 2 && c_a >= 3 * 105) begin
        chk("group1_cin", int'(in_a / 24 == 2 || in_a / 24 == 3), 1);
        chk("group1_oc_mod", (w_a / 27) % 2, 1);
        grp_cnt++;
      end
      tap_cnt++;
    end
    if (cv && rdy) begin
      check_beat(1, 0, 0, 0, c_a, empty);
      commit_cnt++;
      last_commit_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      chk("done_timing", cyc, last_commit_cyc + 1);
      chk("done_busy_low", busy, 0);
    end
  endfunction

  always @(negedge clk) monitor(0, a_tv, a_cv, a_rdy, a_busy, a_done, a_in, a_w, a_ca, a_first, a_empty);
  always @(negedge clk) monitor(1, b_tv, b_cv, b_rdy, b_busy, b_done, b_in, b_w, b_ca, b_first, b_empty);
  always @(negedge clk) monitor(2, c_tv, c_cv, c_rdy, c_busy, c_done, c_in, c_w, c_ca, c_first, c_empty);

  always @(posedge clk) if (rand_en) begin
    #1 a_rdy = 1'($urandom_range(0, 1));
  end

  function automatic logic sel_done(int id);
    return (id == 0) ? a_done : ((id == 1) ? b_done : c_done);
  endfunction

  function automatic logic sel_busy(int id);
    return (id == 0) ? a_busy : ((id == 1) ? b_busy : c_busy);
  endfunction

  task automatic set_start(input int id, input logic v);
    case (id)
      0: a_start = v;
      1: b_start = v;
      default: c_start = v;
    endcase
  endtask

  task automatic start_pulse(input int id);
    @(posedge clk); #1 set_start(id, 1'b1);
    @(posedge clk); #1 set_start(id, 1'b0);
    @(negedge clk);
    chk("busy_after_start", sel_busy(id), 1);
  endtask

  task automatic wait_done(input int id, input int budget);
    int n = 0;
    while (!sel_done(id) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", sel_done(id), 1);
  endtask

  task automatic clear_stats();
    tap_cnt = 0; commit_cnt = 0; done_cnt = 0; grp_cnt = 0; last_commit_cyc = -10;
  endtask

  initial begin
    clear_stats();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_tap_valid", a_tv, 0);
    chk("rst_commit_valid", a_cv, 0);
    chk("rst_tap_first", a_first, 0);
    chk("rst_commit_empty", a_empty, 0);
    chk("rst_in_addr", a_in, 0);
    chk("rst_w_addr", a_w, 0);
    chk("rst_commit_addr", a_ca, 0);

    // Ready high, with a start pulse mid-pass that must be ignored.
    build_model(1, 1, 1, 3, 2, 1, 2, 2, 2);
    a_rdy = 1;
    start_pulse(0);
    repeat (40) @(posedge clk);
    #1 a_start = 1;
    @(posedge clk); #1 a_start = 0;
    wait_done(0, 3000);
    chk("queue_drained_run1", exp_q.size(), 0);
    a_start = 1;
    @(negedge clk);
    chk("start_on_done_ignored", a_busy, 0);
    chk("run1_taps", tap_cnt, 64);
    chk("run1_commits", commit_cnt, 27);
    chk("run1_done_pulses", done_cnt, 1);
    chk("first_tap_in", first_in, 0);
    chk("first_tap_w", first_w, 13);
    chk("first_tap_first", first_first, 1);
    chk("first_tap_commit_addr", first_ca, 0);
    chk("last_tap_in", last_in, 7);
    chk("last_tap_w", last_w, 13);
    chk("last_tap_commit_addr", last_ca, 26);

    // Start held into the IDLE cycle after done begins a new pass with random ready.
    clear_stats();
    build_model(1, 1, 1, 3, 2, 1, 2, 2, 2);
    rand_en = 1;
    @(posedge clk); #1 a_start = 0;
    @(negedge clk);
    chk("start_after_done_accepted", a_busy, 1);
    wait_done(0, 6000);
    rand_en = 0;
    @(posedge clk); #1 a_rdy = 1;
    @(negedge clk);
    chk("run2_taps", tap_cnt, 64);
    chk("run2_commits", commit_cnt, 27);
    chk("run2_done_pulses", done_cnt, 1);
    chk("queue_drained_run2", exp_q.size(), 0);

    // K=1 sparse configuration: pin the model, then compare the DUT against it.
    clear_stats();
    build_model(1, 1, 1, 1, 2, 0, 2, 2, 2);
    chk("model_b0_kind", exp_q[0].is_commit, 0);
    chk("model_b0_in", exp_q[0].in_a, 0);
    chk("model_b1_addr", exp_q[1].c_a, 0);
    chk("model_b1_empty", exp_q[1].empty, 0);
    chk("model_b2_kind", exp_q[2].is_commit, 1);
    chk("model_b2_addr", exp_q[2].c_a, 1);
    chk("model_b2_empty", exp_q[2].empty, 1);
    b_rdy = 1;
    start_pulse(1);
    wait_done(1, 2000);
    @(negedge clk);
    chk("queue_drained_b", exp_q.size(), 0);
    chk("b_commits", commit_cnt, 27);
    chk("b_done_pulses", done_cnt, 1);

    // Default parameters, grouped channels.
    clear_stats();
    build_model(4, 4, 2, 3, 2, 1, 2, 3, 4);
    c_rdy = 1;
    start_pulse(2);
    wait_done(2, 40000);
    @(negedge clk);
    chk("queue_drained_c", exp_q.size(), 0);
    chk("c_commits", commit_cnt, 420);
    chk("group1_taps_seen", int'(grp_cnt > 0), 1);

    // Reset mid-EMIT with the tap stalled.
    clear_stats();
    build_model(1, 1, 1, 3, 2, 1, 2, 2, 2);
    a_rdy = 0;
    start_pulse(0);
    for (int n = 0; n < 200 && !a_tv; n++) @(negedge clk);
    chk("reached_emit", a_tv, 1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("rst_mid_tap_valid", a_tv, 0);
    chk("rst_mid_busy", a_busy, 0);
    chk("rst_mid_commit_valid", a_cv, 0);
    chk("rst_mid_no_done", done_cnt, 0);
    clear_stats();
    build_model(1, 1, 1, 3, 2, 1, 2, 2, 2);
    @(posedge clk); #1 a_rdy = 1;
    start_pulse(0);
    wait_done(0, 3000);
    @(negedge clk);
    chk("restart_first_in", first_in, 0);
    chk("restart_first_w", first_w, 13);
    chk("restart_first_flag", first_first, 1);
    chk("restart_first_commit_addr", first_ca, 0);
    chk("restart_taps", tap_cnt, 64);
    chk("restart_done_pulses", done_cnt, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/conv_transpose3d_tap_sequencer.md
Name: conv_transpose3d_tap_sequencer

Overview:
- Control block for the 3D grouped, strided, padded transposed-convolution datapath. Batch size is 1.
- Walks every output voxel in gather form. For each voxel it issues one address triple (input, weight, output) per contributing tap to the MAC/accumulator datapath over a valid/ready channel.
- After the last tap of each voxel it issues one commit beat so the accumulator is written back.
- Taps that stride or padding make invalid are skipped internally and are never emitted.

Parameters:
- CIN, 4, input channels; divisible by GROUPS.
- COUT, 4, output channels; divisible by GROUPS.
- GROUPS, 2, channel groups.
- K, 3, cubic kernel edge.
- STRIDE, 2, stride; must be a power of two (shift/mask arithmetic, no divider).
- PAD, 1, padding.
- ID, 2, input depth. IH, 3, input height. IW, 4, input width.
- AW, 16, address width. Must hold the largest address of the input, weight and output tensors.
- Derived, not overridable: OD=(ID-1)*STRIDE-2*PAD+K, and likewise OH, OW. CPG=CIN/GROUPS, OPG=COUT/GROUPS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to run a full pass
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final commit handshake
- tap_valid  out  1  tap beat valid
- tap_ready  in  1  datapath accepts tap
- tap_in_addr  out  AW  input address: ((cin*ID+id)*IH+ih)*IW+iw
- tap_w_addr  out  AW  weight address, layout [CIN][OPG][K][K][K]: ((cin*OPG+oc%OPG)*K+kd)*K*K+kh*K+kw
- tap_first  out  1  first emitted tap of the current voxel (datapath clears its accumulator)
- commit_valid  out  1  voxel complete
- commit_ready  in  1  datapath accepts commit
- commit_addr  out  AW  ((oc*OD+od)*OH+oh)*OW+ow; also held stable during the voxel's tap beats
- commit_empty  out  1  voxel had zero valid taps (datapath writes zero)

Behaviour:
- Reset values: busy=0, done=0, tap_valid=0, commit_valid=0, tap_first=0, commit_empty=0, all address outputs 0. FSM goes to IDLE and all counters clear.
- Reset takes priority in any state, including mid-pass with a beat pending. The pass is abandoned and no done pulse is produced.
- Loop order, outermost to innermost: oc, od, oh, ow, kd, kh, kw, ci (0..CPG-1).
  - Group g = oc/OPG.
  - Absolute input channel cin = g*CPG+ci.
- Tap validity, per axis: t = o+PAD-k. The tap is valid iff all of the following hold:
  - t >= 0
  - t & (STRIDE-1) == 0
  - t>>log2(STRIDE) < I, giving i = t>>log2(STRIDE)
  - Validity is independent of ci.
- FSM states:
  - IDLE: start=1 moves to SCAN. busy is registered high the next cycle. start is ignored in every state except IDLE.
  - SCAN: evaluates one (kd,kh,kw) per cycle.
    - Valid: go to EMIT with ci=0.
    - Invalid: advance the kernel index and stay in SCAN.
    - After kernel index (K-1,K-1,K-1) is evaluated: go to COMMIT.
  - EMIT: tap_valid=1.
    - Address outputs and tap_first must stay stable while tap_valid=1 and tap_ready=0.
    - Each handshake increments ci.
    - Handshake with ci=CPG-1: return to SCAN at the next kernel index, or go to COMMIT if that was the last kernel index.
    - tap_first=1 only on the first emitted beat of the voxel.
  - COMMIT: commit_valid=1. commit_empty=1 iff no tap was emitted for this voxel. Hold until commit_ready.
    - Handshake: advance ow, then oh, od, oc, and go to SCAN.
    - Handshake on the final voxel: go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- tap_valid and commit_valid are never high in the same cycle. There is no combinational path from ready to valid.
- With ready held high, throughput is 1 cycle per SCAN evaluation plus 1 cycle per emitted tap plus 1 cycle per commit.
- All address arithmetic is unsigned and computed in registers, with no truncation inside AW.

Test Plan:
- CIN=COUT=GROUPS=1, K=3, STRIDE=2, PAD=1, ID=IH=IW=2 (O=3), ready tied high:
  - exactly 64 taps and 27 commits;
  - first tap: in_addr 0, w_addr 13, tap_first=1, commit_addr 0;
  - last tap: in_addr 7, w_addr 13, commit_addr 26;
  - done pulses once, the cycle after the final commit handshake.
- Same config, tap_ready toggled pseudo-randomly: the address sequence is identical to the run above, and outputs stay stable whenever valid=1 and ready=0.
- K=1, STRIDE=2, PAD=0, I=2 on all axes (O=3): voxel (0,0,1) commits with commit_empty=1 after zero taps; voxel (0,0,0) has 1 tap with in_addr 0.
- Default parameters: for oc=3 (group 1), every tap has cin in {2,3}, and w_addr uses oc%OPG=1.
- Assert rst mid-EMIT with tap_ready=0: the next cycle shows tap_valid=0, busy=0, IDLE. A fresh start then reproduces the first tap of the first scenario.
- Pulse start while busy: ignored. Pulse start the same cycle done is high: ignored. Pulse start one cycle after done: a new pass begins.
